// File: rtl/reorder_buffer_pkg.sv
// Shared types and sizing for the reorder buffer: entry layout and q-port source select.
package reorder_buffer_pkg;

  localparam int unsigned ROB_SIZE  = 16;
  localparam int unsigned ROB_IDX_W = 4;
  localparam int unsigned REG_IDX_W = 5;
  localparam int unsigned XLEN      = 32;

  localparam logic [ROB_IDX_W-1:0] TAG_NONE = '0;

  typedef struct packed {
    logic                 busy;
    logic                 ready;
    logic                 latest;
    logic [REG_IDX_W-1:0] rd;
    logic [XLEN-1:0]      val;
  } rob_entry_t;

  typedef enum logic [1:0] {
    Q_IDLE,
    Q_RENAME,
    Q_CLEAR
  } q_src_e;

endpackage

// File: rtl/reorder_buffer_entry_array.sv
// Entry storage for the reorder buffer: allocation, CDB capture, retirement and
// newest-producer tracking per destination register.
module rob_entry_array
  import reorder_buffer_pkg::*;
(
  input  logic                 clk_in,
  input  logic                 rst_in,
  input  logic                 en,
  input  logic                 alloc_en,
  input  logic [ROB_IDX_W-1:0] alloc_idx,
  input  logic [REG_IDX_W-1:0] alloc_rd,
  input  logic                 cdb_valid,
  input  logic [ROB_IDX_W-1:0] cdb_tag,
  input  logic [XLEN-1:0]      cdb_val,
  input  logic                 retire_en,
  input  logic [ROB_IDX_W-1:0] head_idx,
  output rob_entry_t           head_entry
);

  rob_entry_t ent [ROB_SIZE];

  assign head_entry = ent[head_idx];

  // Later assignments in the loop body deliberately override earlier ones:
  // allocation replaces the whole entry, retirement only drops busy.
  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      for (int unsigned i = 0; i < ROB_SIZE; i++) ent[i] <= '0;
    end else if (en) begin
      for (int unsigned i = 0; i < ROB_SIZE; i++) begin
        if (cdb_valid && ent[i].busy && (cdb_tag == ROB_IDX_W'(i))) begin
          ent[i].val   <= cdb_val;
          ent[i].ready <= 1'b1;
        end
        if (retire_en && (head_idx == ROB_IDX_W'(i))) begin
          ent[i].busy <= 1'b0;
        end
        if (alloc_en && (alloc_idx != ROB_IDX_W'(i)) && ent[i].busy &&
            (alloc_rd != '0) && (ent[i].rd == alloc_rd)) begin
          ent[i].latest <= 1'b0;
        end
        if (alloc_en && (alloc_idx == ROB_IDX_W'(i))) begin
          ent[i] <= '{busy: 1'b1, ready: 1'b0, latest: 1'b1, rd: alloc_rd, val: '0};
        end
      end
    end
  end

endmodule

// File: rtl/reorder_buffer.sv
// In-order retirement buffer: allocates tags on issue, renames rd, captures CDB
// results and retires the head in program order to the register file.
module reorder_buffer
  import reorder_buffer_pkg::*;
(
  input  logic                 clk_in,
  input  logic                 rst_in,
  input  logic                 rdy_in,
  input  logic                 issue_valid,
  input  logic [REG_IDX_W-1:0] issue_rd,
  output logic                 issue_full,
  output logic [ROB_IDX_W-1:0] issue_tag,
  input  logic                 cdb_valid,
  input  logic [ROB_IDX_W-1:0] cdb_tag,
  input  logic [XLEN-1:0]      cdb_val,
  output logic [REG_IDX_W-1:0] set_reg,
  output logic [XLEN-1:0]      set_val,
  output logic [REG_IDX_W-1:0] set_reg_q,
  output logic [XLEN-1:0]      set_val_q,
  output logic                 set_rdy_q
);

  logic [ROB_IDX_W-1:0] head, tail;
  logic [ROB_IDX_W:0]   count;
  rob_entry_t           head_e;
  logic                 accept, rename, commit, need_clr;
  q_src_e               q_src;

  assign issue_full = (count == (ROB_IDX_W + 1)'(ROB_SIZE));
  assign issue_tag  = tail;

  rob_entry_array u_entries (
    .clk_in     (clk_in),
    .rst_in     (rst_in),
    .en         (rdy_in),
    .alloc_en   (accept),
    .alloc_idx  (tail),
    .alloc_rd   (issue_rd),
    .cdb_valid  (cdb_valid),
    .cdb_tag    (cdb_tag),
    .cdb_val    (cdb_val),
    .retire_en  (commit),
    .head_idx   (head),
    .head_entry (head_e)
  );

  // A rename owns the q port; a clearing commit for a different rd waits a cycle,
  // while a same-rd rename supersedes the clear so the commit may proceed.
  always_comb begin
    accept   = rdy_in & issue_valid & ~issue_full;
    rename   = accept & (issue_rd != '0);
    need_clr = head_e.latest & (head_e.rd != '0);
    commit   = rdy_in & head_e.busy & head_e.ready &
               ~(need_clr & rename & (issue_rd != head_e.rd));
    q_src    = Q_IDLE;
    if (rename)                q_src = Q_RENAME;
    else if (commit && need_clr) q_src = Q_CLEAR;
  end

  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else begin
      if (accept) tail <= tail + 1'b1;
      if (commit) head <= head + 1'b1;
      case ({accept, commit})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      set_reg   <= '0;
      set_val   <= '0;
      set_reg_q <= '0;
      set_val_q <= '0;
      set_rdy_q <= 1'b0;
    end else begin
      set_reg <= commit ? head_e.rd  : '0;
      set_val <= commit ? head_e.val : '0;
      case (q_src)
        Q_RENAME: begin
          set_reg_q <= issue_rd;
          set_val_q <= XLEN'(tail);
          set_rdy_q <= 1'b0;
        end
        Q_CLEAR: begin
          set_reg_q <= head_e.rd;
          set_val_q <= XLEN'(TAG_NONE);
          set_rdy_q <= 1'b1;
        end
        default: begin
          set_reg_q <= '0;
          set_val_q <= '0;
          set_rdy_q <= 1'b0;
        end
      endcase
    end
  end

endmodule
